// File: rtl/adder_pkg.sv
// adder_pkg: shared slice arithmetic and stage-count helpers for the pipelined adder
package adder_pkg;
  localparam int MAX_CHUNK = 64;
  function automatic int stage_count(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic logic [MAX_CHUNK:0] slice_add(input logic [MAX_CHUNK-1:0] x, input logic [MAX_CHUNK-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{MAX_CHUNK{1'b0}}, c};
  endfunction
endpackage

// File: rtl/adder_stage.sv
// adder_stage: one pipeline register resolving one CHUNK-bit slice of the sum
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c
);
  localparam int LO = K * CHUNK;
  logic             load;
  logic             c_nxt;
  logic [CHUNK-1:0] slice;
  logic [WIDTH-1:0] s_nxt;
  assign load     = ~out_valid | out_ready;
  assign in_ready = load;
  assign {c_nxt, slice} = (CHUNK+1)'(slice_add(MAX_CHUNK'(in_a[LO+:CHUNK]), MAX_CHUNK'(in_b[LO+:CHUNK]), in_c));
  // splice this stage's slice into the partial sum carried down the pipe
  always_comb begin
    s_nxt = in_s;
    s_nxt[LO+:CHUNK] = slice;
  end
  // stage register: refills whenever empty or being drained downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_s     <= '0;
      out_c     <= 1'b0;
    end else begin
      if (load) out_valid <= in_valid;
      if (load && in_valid) begin
        out_a <= in_a;
        out_b <= in_b;
        out_s <= s_nxt;
        out_c <= c_nxt;
      end
    end
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into CHUNK-bit slices, one per stage, with valid/ready flow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = stage_count(WIDTH, CHUNK);
  if (WIDTH % CHUNK != 0 || CHUNK > MAX_CHUNK) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK and CHUNK at most MAX_CHUNK");
  end
  logic [STAGES:0] v;
  logic [STAGES:0] r;
  logic [STAGES:0] pc;
  logic [WIDTH-1:0] pa [STAGES+1];
  logic [WIDTH-1:0] pb [STAGES+1];
  logic [WIDTH-1:0] ps [STAGES+1];
  assign v[0]      = in_valid;
  assign r[STAGES] = out_ready;
  assign pa[0]     = a;
  assign pb[0]     = sub ? ~b : b;
  assign ps[0]     = '0;
  assign pc[0]     = sub | cin;
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(i)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (v[i]),
      .in_ready (r[i]),
      .in_a     (pa[i]),
      .in_b     (pb[i]),
      .in_s     (ps[i]),
      .in_c     (pc[i]),
      .out_valid(v[i+1]),
      .out_ready(r[i+1]),
      .out_a    (pa[i+1]),
      .out_b    (pb[i+1]),
      .out_s    (ps[i+1]),
      .out_c    (pc[i+1])
    );
  end
  assign in_ready  = r[0];
  assign out_valid = v[STAGES];
  assign sum       = ps[STAGES];
  assign cout      = pc[STAGES];
  assign ovf       = (pa[STAGES][WIDTH-1] == pb[STAGES][WIDTH-1]) & (ps[STAGES][WIDTH-1] != pa[STAGES][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and scoreboard checks of the pipelined adder
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] sb[$];
  logic [17:0] cap;

  pipelined_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
    logic [15:0] be;
    logic [16:0] res;
    be  = s ? ~y : y;
    res = {1'b0, x} + {1'b0, be} + {16'b0, s | ci};
    return {res[15:0], res[16], (x[15] == be[15]) && (res[15] != x[15])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s, input logic [17:0] exp);
    bit acc = 1'b0;
    a = x;
    b = y;
    cin = ci;
    sub = s;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc) sb.push_back(exp);
    else chk("accept_timeout", 32'(in_ready), 32'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1 chk(tag, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else chk("result", 32'({sum, cout, ovf}), 32'(sb.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_outputs", 32'({sum, cout, ovf}), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("reset_in_ready", 32'(in_ready), 32'd1);

    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("latency", 32'(out_valid), 32'(i == 3));
    end
    @(posedge clk);
    #1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    wait_drain("directed_drain");

    out_ready = 1'b0;
    fork
      begin
        logic [15:0] x, y;
        logic ci, s;
        for (int i = 0; i < 8; i++) begin
          x  = 16'($urandom);
          y  = 16'($urandom);
          ci = 1'($urandom);
          s  = 1'($urandom);
          send(x, y, ci, s, model(x, y, ci, s));
        end
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        cap = {sum, cout, ovf};
        @(posedge clk);
        #1;
        chk("bp_hold", 32'({sum, cout, ovf}), 32'(cap));
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("bp_stream", 32'(out_valid), 32'd1);
        end
      end
    join
    wait_drain("bp_drain");

    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, model(16'h1234, 16'h1111, 1'b0, 1'b0));
    send(16'hA000, 16'h0FFF, 1'b1, 1'b0, model(16'hA000, 16'h0FFF, 1'b1, 1'b0));
    send(16'h0003, 16'h0009, 1'b0, 1'b1, model(16'h0003, 16'h0009, 1'b0, 1'b1));
    @(posedge clk);
    #1 chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_outputs", 32'({sum, cout, ovf}), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1 chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    wait_drain("post_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
